// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern detector and its word-wide controller.
package seq_det_pkg;

    localparam int         DEF_DATA_W  = 8;
    localparam int         DEF_PAT_W   = 3;
    localparam logic [2:0] SEQ_PAT_101 = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_pattern_match.sv
// Mealy serial pattern matcher: keeps the last PAT_W-1 bits and flags a match on the current bit.
module seq_pattern_match
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = SEQ_PAT_101
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    localparam int              HV_W    = $clog2(PAT_W);
    localparam logic [HV_W-1:0] HV_FULL = HV_W'(PAT_W - 1);

    logic [PAT_W-2:0] history;
    logic [HV_W-1:0]  hist_vld;
    logic [PAT_W-1:0] window;

    assign window = {history, bit_in};
    assign hit    = en && (hist_vld == HV_FULL) && (window == PATTERN);

    // NOTE: sequential state is written with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            history  <= '0;
            hist_vld <= '0;
        end else if (en) begin
            history <= window[PAT_W-2:0];
            if (hist_vld != HV_FULL)
                hist_vld <= hist_vld + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-wide wrapper: serialises each accepted word MSB-first through the matcher and returns the match count.
// Define SEQ_DET_CARRY_HIST_EN to carry matcher history across words so matches may span two words.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int               DATA_W  = DEF_DATA_W,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = SEQ_PAT_101,
    localparam int              CNT_W   = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_any,
    output logic              bit_out,
    output logic              hit
);

    localparam int              BC_W     = $clog2(DATA_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [BC_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  count_next;
    logic              accept;
    logic              shifting;
    logic              clr_hist;

    assign accept     = in_valid && in_ready;
    assign shifting   = (state == ST_SHIFT);
    assign bit_out    = shifting && shift_reg[DATA_W-1];
    assign count_next = hit_cnt + CNT_W'(hit);

`ifdef SEQ_DET_CARRY_HIST_EN
    assign clr_hist = 1'b0;
`else
    assign clr_hist = accept;
`endif

    seq_pattern_match #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_match (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_hist),
        .en      (shifting),
        .bit_in  (bit_out),
        .hit     (hit)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            hit_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_count <= '0;
            out_any   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shift_reg <= in_data;
                        bit_cnt   <= '0;
                        hit_cnt   <= '0;
                        in_ready  <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                    hit_cnt   <= count_next;
                    // Final bit's hit is folded in directly so the result is complete on entry to DONE.
                    if (bit_cnt == LAST_BIT) begin
                        out_count <= count_next;
                        out_any   <= (count_next != '0);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: vector table with per-bit hit checks plus handshake/reset corner cases.
module tb_seq_detect_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_ready;
    logic              out_valid;
    logic [CNT_W-1:0]  out_count;
    logic              out_any;
    logic              bit_out;
    logic              hit;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic [7:0] hit_mask;
        int         count;
    } vec_t;

    vec_t vecs[6];

    seq_detect_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_any   (out_any),
        .bit_out   (bit_out),
        .hit       (hit)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_word(input logic [7:0] d, input bit push, input int exp);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        if (push)
            exp_q.push_back(exp);
    endtask

    // Checks each serial bit and hit strobe, MSB first, during the DATA_W shift cycles.
    task automatic shift_bits(input logic [7:0] d, input logic [7:0] mask);
        for (int k = 0; k < DATA_W; k++) begin
            check($sformatf("bit_out[%0d]", k), bit_out, d[7-k]);
            check($sformatf("hit[%0d]", k), hit, mask[7-k]);
            check($sformatf("busy_valid[%0d]", k), out_valid, 0);
            check($sformatf("busy_ready[%0d]", k), in_ready, 0);
            tick();
        end
    endtask

    task automatic collect();
        int waited = 0;
        int exp;
        while (!out_valid && waited < 50) begin
            tick();
            waited++;
        end
        check("out_valid_seen", out_valid, 1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: result %0d with no expected entry", out_count);
        end else begin
            exp = exp_q.pop_front();
            check("out_count", out_count, exp);
            check("out_any", out_any, (exp != 0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handshake_valid_drop", out_valid, 0);
    endtask

    initial begin
        int  waited;
        bit  carry;
        vecs[0] = '{8'b10101101, 8'b00101001, 3};
        vecs[1] = '{8'b11111111, 8'b00000000, 0};
        vecs[2] = '{8'b00000000, 8'b00000000, 0};
        vecs[3] = '{8'b01010101, 8'b00010101, 3};
        vecs[4] = '{8'b11011011, 8'b00010010, 2};
        vecs[5] = '{8'b10100000, 8'b00100000, 1};
`ifdef SEQ_DET_CARRY_HIST_EN
        carry = 1'b1;
`else
        carry = 1'b0;
`endif

        // Reset held three cycles, then idle with in_valid low.
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3)
                reset_n = 1'b1;
            tick();
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_count", out_count, 0);
            check("rst_hit", hit, 0);
            check("rst_bit_out", bit_out, 0);
        end

        // Table: per-bit hits, latency of DATA_W edges to out_valid, and counts.
        for (int v = 0; v < 6; v++) begin
            accept_word(vecs[v].data, 1'b1, vecs[v].count);
            shift_bits(vecs[v].data, vecs[v].hit_mask);
            check("latency_valid", out_valid, 1);
            collect();
        end

        // Back-to-back words: a match spanning the boundary counts only with history carry.
        accept_word(8'b00000010, 1'b1, 0);
        collect();
        accept_word(8'b10000000, 1'b1, carry ? 1 : 0);
        collect();

        // Backpressure: result held stable, new word waits for the handshake.
        accept_word(8'b10101101, 1'b1, 3);
        waited = 0;
        while (!out_valid && waited < 50) begin
            tick();
            waited++;
        end
        check("bp_valid_seen", out_valid, 1);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_hold", out_valid, 1);
            check("bp_count_hold", out_count, exp_q.size() > 0 ? exp_q[0] : -1);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        check("bp_count_final", out_count, exp_q.size() > 0 ? exp_q.pop_front() : -1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_after_hs_valid", out_valid, 0);
        check("bp_after_hs_ready", in_ready, 1);
        check("bp_after_hs_bit", bit_out, 0);
        tick();
        in_valid = 1'b0;
        exp_q.push_back(0);
        check("bp_accepted_ready", in_ready, 0);
        check("bp_accepted_bit", bit_out, 1);
        collect();

        // Reset at bit 4 discards the word; the next word is scanned from clean history.
        accept_word(8'b10101101, 1'b0, 0);
        repeat (4) tick();
        check("abort_hit_bit4", hit, 1);
        reset_n = 1'b0;
        tick();
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_hit", hit, 0);
        check("abort_bit_out", bit_out, 0);
        check("abort_count", out_count, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_no_result", out_valid, 0);
        end
        accept_word(8'b10100000, 1'b1, 1);
        shift_bits(8'b10100000, 8'b00100000);
        collect();

        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
